// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, reset pc, compressed-length marker,
// fetch FSM states and the memory word payload.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam int unsigned HW_W = 16;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [1:0]      RVC_NONE     = 2'b11;

    typedef enum logic [0:0] {
        FS_FETCH = 1'b0,
        FS_DRAIN = 1'b1
    } fetch_state_e;

    // Little-endian memory word split into its two halfwords
    typedef struct packed {
        logic [HW_W-1:0] hi;
        logic [HW_W-1:0] lo;
    } imem_word_t;

    function automatic logic is_rvc(input logic [1:0] hw_lo2);
        return hw_lo2 != RVC_NONE;
    endfunction

endpackage

// File: rtl/fetch_hw_buffer.sv
// Halfword shift buffer: head at slot 0, pops shift toward the head, pushes append
// behind the surviving entries in the same cycle.
module fetch_hw_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned BUF_HW = 4,
    localparam int unsigned CNT_W = $clog2(BUF_HW + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push1,
    input  logic             push2,
    input  logic [HW_W-1:0]  push_lo,
    input  logic [HW_W-1:0]  push_hi,
    input  logic             pop1,
    input  logic             pop2,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [HW_W-1:0]  head0,
    output logic [HW_W-1:0]  head1
);

    localparam int unsigned BUF_W = BUF_HW * HW_W;

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] ins;
    logic [BUF_W-1:0] ins_mask;
    logic [CNT_W-1:0] n_pop;
    logic [CNT_W-1:0] n_push;
    logic [CNT_W-1:0] base;

    // A single push carries only the upper halfword (odd-halfword fetch target)
    always_comb begin
        n_pop    = pop2  ? CNT_W'(2) : (pop1  ? CNT_W'(1) : '0);
        n_push   = push2 ? CNT_W'(2) : (push1 ? CNT_W'(1) : '0);
        base     = cnt_q - n_pop;
        shifted  = buf_q >> (HW_W * n_pop);
        ins      = '0;
        ins_mask = '0;
        if (push2) begin
            ins      = BUF_W'({push_hi, push_lo});
            ins_mask = BUF_W'({(2 * HW_W){1'b1}});
        end else if (push1) begin
            ins      = BUF_W'(push_hi);
            ins_mask = BUF_W'({HW_W{1'b1}});
        end

        buf_d = buf_q;
        cnt_d = cnt_q;
        if (flush) begin
            buf_d = '0;
            cnt_d = '0;
        end else begin
            buf_d = (shifted & ~(ins_mask << (HW_W * base))) | (ins << (HW_W * base));
            cnt_d = base + n_push;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head0 = buf_q[HW_W-1:0];
    assign head1 = buf_q[2*HW_W-1:HW_W];

endmodule

// File: rtl/fetch_align.sv
// Instruction fetch/align front end: fetches little-endian words, realigns the RVC/RV32
// halfword stream and hands one instruction per handshake to the decoder.
module fetch_align
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     BUF_HW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned     CNT_W     = $clog2(BUF_HW + 1);
    localparam logic [0:0]      ST_FETCH  = FS_FETCH;
    localparam logic [0:0]      ST_DRAIN  = FS_DRAIN;
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
    localparam logic [CNT_W-1:0] REQ_MAX  = CNT_W'(BUF_HW - 2);

    logic [0:0]      state_q, state_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            odd_q, odd_d;

    logic [CNT_W-1:0] buf_count;
    logic [HW_W-1:0]  head0;
    logic [HW_W-1:0]  head1;
    logic             head_rvc;
    logic             xfer;
    logic             ack_take;
    logic             pop1, pop2, push1, push2;
    logic [CNT_W-1:0] n_pop, n_push, count_after;
    imem_word_t       rword;

    // Handshake qualification; redirect overrides both the pop and the push
    always_comb begin
        rword       = imem_word_t'(imem_rdata);
        head_rvc    = is_rvc(head0[1:0]);
        instr_valid = ((buf_count != '0) && head_rvc) || (buf_count >= CNT_W'(2));
        xfer        = instr_valid && instr_ready && !redirect;
        pop1        = xfer && head_rvc;
        pop2        = xfer && !head_rvc;
        ack_take    = imem_ack && req_q && (state_q == ST_FETCH) && !redirect;
        push1       = ack_take && odd_q;
        push2       = ack_take && !odd_q;
        n_pop       = pop2  ? CNT_W'(2) : (pop1  ? CNT_W'(1) : '0);
        n_push      = push2 ? CNT_W'(2) : (push1 ? CNT_W'(1) : '0);
        count_after = buf_count - n_pop + n_push;
    end

    // Swizzle the head into decoder byte order (byte at pc in the top byte)
    always_comb begin
        instr_data = '0;
        if (instr_valid) begin
            if (head_rvc) begin
                instr_data = {head0[7:0], head0[15:8], 16'h0000};
            end else begin
                instr_data = {head0[7:0], head0[15:8], head1[7:0], head1[15:8]};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        odd_d   = odd_q;

        if (redirect) begin
            pc_d = {redirect_pc[XLEN-1:1], 1'b0};
        end else if (xfer) begin
            pc_d = pc_q + (head_rvc ? XLEN'(2) : XLEN'(4));
        end

        case (state_q)
            ST_FETCH: begin
                if (redirect) begin
                    odd_d = redirect_pc[1];
                    if (req_q && !imem_ack) begin
                        state_d = ST_DRAIN;
                        tgt_d   = redirect_pc & WORD_MASK;
                    end else begin
                        addr_d = redirect_pc & WORD_MASK;
                        req_d  = 1'b1;
                    end
                end else if (!req_q || imem_ack) begin
                    if (req_q) begin
                        addr_d = addr_q + XLEN'(4);
                        odd_d  = 1'b0;
                    end
                    // Room for a full word must remain once this cycle settles
                    req_d = (count_after <= REQ_MAX);
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    tgt_d = redirect_pc & WORD_MASK;
                    odd_d = redirect_pc[1];
                end
                if (imem_ack) begin
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                    addr_d  = redirect ? (redirect_pc & WORD_MASK) : tgt_q;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC & WORD_MASK;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC & WORD_MASK;
            odd_q   <= RESET_PC[1];
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            odd_q   <= odd_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign instr_pc  = pc_q;

    fetch_hw_buffer #(
        .BUF_HW (BUF_HW)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .push1   (push1),
        .push2   (push2),
        .push_lo (rword.lo),
        .push_hi (rword.hi),
        .pop1    (pop1),
        .pop2    (pop2),
        .flush   (redirect),
        .count   (buf_count),
        .head0   (head0),
        .head1   (head1)
    );

endmodule

// File: tb/tb_fetch_align.sv
// Bench for fetch_align: directed scenarios plus a randomized run checked against a
// program-order model of the instruction stream held in a small memory image.
module tb_fetch_align;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_align #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] mem [256];
    int unsigned max_lat  = 0;
    int unsigned lat      = 0;
    int unsigned ack_cnt  = 0;
    int unsigned xfer_cnt = 0;
    logic        hold_ack = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: the instruction at pc is read straight out of the memory image
    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic [31:0] ref_instr(input logic [31:0] pc);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = hw_at(pc);
        hi = hw_at(pc + 32'd2);
        if (lo[1:0] != 2'b11) return {lo[7:0], lo[15:8], 16'h0000};
        return {lo[7:0], lo[15:8], hi[7:0], hi[15:8]};
    endfunction

    function automatic logic [31:0] ref_len(input logic [31:0] pc);
        logic [15:0] lo;
        lo = hw_at(pc);
        return (lo[1:0] == 2'b11) ? 32'd4 : 32'd2;
    endfunction

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 256; i++) mem[i] = w;
    endtask

    task automatic fill_random();
        logic [15:0] h [2];
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 2; k++) begin
                h[k] = 16'($urandom);
                if ($urandom_range(1, 0) == 0) h[k][1:0] = 2'b11;
                else if (h[k][1:0] == 2'b11) h[k][1:0] = 2'b01;
            end
            mem[i] = {h[1], h[0]};
        end
    endtask

    // Memory: acks a pending request after a random number of cycles
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (!reset) begin
                lat = 0;
            end else if (imem_req && !hold_ack) begin
                if (lat == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr[9:2]];
                    ack_cnt++;
                    lat = $urandom_range(max_lat, 0);
                end else begin
                    lat--;
                end
            end
        end
    end

    // Stream monitor: every accepted instruction must follow program order
    initial begin
        logic [31:0] exp_pc, p_data, p_pc, p_addr;
        logic        p_ok, p_stall, p_redir, p_req, p_ack;
        exp_pc = RESET_PC;
        p_ok = 1'b0; p_stall = 1'b0; p_redir = 1'b0; p_req = 1'b0; p_ack = 1'b0;
        p_data = '0; p_pc = '0; p_addr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_pc = RESET_PC;
                p_ok   = 1'b0;
            end else begin
                if (p_ok) begin
                    if (p_stall) begin
                        check_eq("stall_data", instr_data, p_data);
                        check_eq("stall_pc", instr_pc, p_pc);
                        check_eq("stall_valid", 32'(instr_valid), 32'd1);
                    end
                    if (p_redir) check_eq("redir_flush", 32'(instr_valid), 32'd0);
                    if (p_req && !p_ack) begin
                        check_eq("req_hold", 32'(imem_req), 32'd1);
                        check_eq("addr_hold", imem_addr, p_addr);
                    end
                end
                if (imem_req) check_eq("addr_align", imem_addr & 32'd3, 32'd0);
                if (redirect) begin
                    exp_pc = redirect_pc & ~32'd1;
                end else if (instr_valid && instr_ready) begin
                    check_eq("xfer_pc", instr_pc, exp_pc);
                    check_eq("xfer_data", instr_data, ref_instr(exp_pc));
                    exp_pc = exp_pc + ref_len(exp_pc);
                    xfer_cnt++;
                end
                p_ok    = 1'b1;
                p_stall = instr_valid && !instr_ready && !redirect;
                p_redir = redirect;
                p_req   = imem_req;
                p_ack   = imem_ack;
                p_addr  = imem_addr;
                p_data  = instr_data;
                p_pc    = instr_pc;
            end
        end
    end

    task automatic hold_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    task automatic reset_check(input string tag);
        reset = 1'b0;
        #1;
        check_eq({tag, "_req"}, 32'(imem_req), 32'd0);
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check_eq({tag, "_data"}, instr_data, 32'd0);
        check_eq({tag, "_pc"}, instr_pc, RESET_PC);
        check_eq({tag, "_addr"}, imem_addr, RESET_PC & ~32'd3);
    endtask

    task automatic release_reset(input string tag);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_req1"}, 32'(imem_req), 32'd1);
        check_eq({tag, "_addr1"}, imem_addr, RESET_PC & ~32'd3);
        check_eq({tag, "_empty"}, 32'(instr_valid), 32'd0);
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] d, input logic [31:0] pc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = instr_valid && instr_ready;
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check_eq({tag, "_data"}, instr_data, d);
            check_eq({tag, "_pc"}, instr_pc, pc);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        seen;
        logic        last_redir;
        int unsigned xfer_start;

        reset       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        // Single 32-bit instruction
        fill(32'h0001_0001);
        mem[0] = 32'h00A0_0093;
        instr_ready = 1'b1;
        release_reset("t1");
        expect_instr("t1", 32'h9300_A000, 32'h0);

        // Two RVC in one word
        hold_reset();
        fill(32'h0001_0001);
        mem[0] = 32'h4581_4501;
        release_reset("t2");
        expect_instr("t2a", 32'h0145_0000, 32'h0);
        expect_instr("t2b", 32'h8145_0000, 32'h2);

        // 32-bit instruction straddling two words
        hold_reset();
        fill(32'h0001_0001);
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h4501_00A0;
        release_reset("t3");
        expect_instr("t3a", 32'h0145_0000, 32'h0);
        expect_instr("t3b", 32'h9300_A000, 32'h2);
        expect_instr("t3c", 32'h0145_0000, 32'h6);

        // Decoder stall: outputs hold, fetch stops with the buffer full
        hold_reset();
        fill(32'h00A0_0093);
        instr_ready = 1'b0;
        ack_cnt = 0;
        release_reset("t4");
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = instr_valid;
        end
        check_eq("t4_valid", 32'(seen), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("t4_data", instr_data, 32'h9300_A000);
            check_eq("t4_pc", instr_pc, 32'h0);
        end
        check_eq("t4_acks", ack_cnt, 32'd2);
        check_eq("t4_req_idle", 32'(imem_req), 32'd0);
        @(posedge clk);
        #3;
        reset_check("t6_stall");

        // Redirect to an odd halfword while a request is outstanding
        fill(32'h0001_0001);
        mem[0]    = 32'h00A0_0093;
        mem[8'h40] = 32'h4501_0013;
        hold_ack    = 1'b1;
        instr_ready = 1'b1;
        release_reset("t5");
        @(posedge clk);
        #2;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        @(posedge clk);
        #2;
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("t5_req_held", 32'(imem_req), 32'd1);
            check_eq("t5_addr_held", imem_addr, 32'h0);
            check_eq("t5_no_valid", 32'(instr_valid), 32'd0);
        end
        hold_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = imem_ack;
        end
        check_eq("t5_ack", 32'(seen), 32'd1);
        @(negedge clk);
        check_eq("t5_req_new", 32'(imem_req), 32'd1);
        check_eq("t5_addr_new", imem_addr, 32'h0000_0100);
        expect_instr("t5a", 32'h0145_0000, 32'h0000_0102);
        expect_instr("t5b", 32'h0100_0000, 32'h0000_0104);

        // Reset while a request is waiting on memory
        hold_ack = 1'b1;
        hold_reset();
        release_reset("t6_pre");
        #2;
        reset_check("t6_req");
        release_reset("t6_rel");
        hold_ack = 1'b0;
        expect_instr("t6_first", 32'h9300_A000, 32'h0);

        // Randomized program, memory latency, back-pressure and redirects
        hold_reset();
        fill_random();
        max_lat = 3;
        release_reset("rnd");
        xfer_start = xfer_cnt;
        last_redir = 1'b0;
        repeat (3000) begin
            @(posedge clk);
            #2;
            instr_ready = ($urandom_range(3, 0) != 0);
            redirect    = !last_redir && ($urandom_range(29, 0) == 0);
            redirect_pc = $urandom;
            last_redir  = redirect;
        end
        @(posedge clk);
        #2;
        redirect = 1'b0;
        repeat (4) @(posedge clk);
        check_eq("rnd_progress", 32'(xfer_cnt - xfer_start > 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
